// File: rtl/ripple_counter.sv
`timescale 1ns/100ps
`default_nettype none
// ============================================================================
//  Module   : ripple_counter
//  Purpose  : 8-bit up-counter with count enable, built as a chain of eight
//             toggle stages. The toggle enables ripple from bit 0 upward
//             through an AND chain, with no carry look-ahead.
//  Ports    :
//    clk    in   1  system clock; all state changes on its rising edge
//    reset  in   1  synchronous active-high clear; has priority over d
//    d      in   1  count enable; 1 = increment, 0 = hold
//    q      out  8  current count (q[0] is the LSB), straight from the stages
//  Revision : 1.0  initial release
// ============================================================================
module ripple_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       d,
  output logic [7:0] q
);

  localparam int c_WIDTH = 8;

  // Stage registers. The declaration initialiser gives a defined power-up
  // value, so q reads zero rather than X before the first reset.
  logic [c_WIDTH-1:0] count_q = '0;
  logic [c_WIDTH-1:0] count_d;

  // Toggle enable per stage: stage i flips only when d is high and every
  // lower stage is already 1.
  logic [c_WIDTH-1:0] w_toggle;

  assign w_toggle[0] = d;

  // Enable chain. Each link reuses the enable of the stage below, so the
  // path into the top stage is a serial chain of seven ANDs.
  generate
    for (genvar i = 1; i < c_WIDTH; i++) begin : g_chain
      assign w_toggle[i] = w_toggle[i-1] & count_q[i-1];
    end
  endgenerate

  // Toggle flip-flop next-state function: hold when the enable is low,
  // invert when it is high.
  generate
    for (genvar i = 0; i < c_WIDTH; i++) begin : g_stage
      assign count_d[i] = count_q[i] ^ w_toggle[i];
    end
  endgenerate

  // All stages share one clock. Reset wins over the count enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign q = count_q;

endmodule
`default_nettype wire

// File: tb/tb_ripple_counter.sv
`timescale 1ns/100ps
`default_nettype none
// ============================================================================
//  Module   : tb_ripple_counter
//  Purpose  : Self-checking bench for ripple_counter. Directed vectors with
//             hand-computed expectations, plus hand-written sequences for
//             mid-cycle input changes, wrap, reset priority and a phase with
//             free-running asynchronous d/reset against a reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ripple_counter;

  logic       clk;
  logic       reset;
  logic       d;
  logic [7:0] q;

  int total = 0;
  int bad   = 0;

  ripple_counter dut (
    .clk   (clk),
    .reset (reset),
    .d     (d),
    .q     (q)
  );

  // 40 ns period, rising edges at 20, 60, 100, ...
  initial begin
    clk = 1'b0;
    forever #20 clk = ~clk;
  end

  typedef struct {
    logic       rst;
    logic       en;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic en, input logic [7:0] exp);
    vec_t v;
    v.rst = r;
    v.en  = en;
    v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [7:0] exp);
    total++;
    if (q !== exp) begin
      bad++;
      $display("FAIL %s: q=%h expected=%h at %0t", name, q, exp, $time);
    end
  endtask

  // Drive inputs, take one rising edge, settle 1 ns past it.
  task automatic step(input logic r, input logic en);
    reset = r;
    d     = en;
    @(posedge clk);
    #1;
  endtask

  task automatic run_table(input string tag, input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      step(vecs[i].rst, vecs[i].en);
      check($sformatf("%s[%0d]", tag, i), vecs[i].exp);
    end
  endtask

  logic [7:0] model_q;
  logic       smp_r;
  logic       smp_d;

  initial begin
    reset = 1'b0;
    d     = 1'b0;

    // Vectors 0..3: power-up hold; 4..13: count 1..10;
    // 14..19: reset then count to 5; 20..23: enable gating 6,6,7,7.
    for (int i = 0; i < 4; i++)  add(1'b0, 1'b0, 8'h00);
    for (int i = 1; i <= 10; i++) add(1'b0, 1'b1, 8'(i));
    add(1'b1, 1'b0, 8'h00);
    for (int i = 1; i <= 5; i++)  add(1'b0, 1'b1, 8'(i));
    add(1'b0, 1'b1, 8'h06);
    add(1'b0, 1'b0, 8'h06);
    add(1'b0, 1'b1, 8'h07);
    add(1'b0, 1'b0, 8'h07);
    // 24..26: wrap FE -> FF, 00, 01
    add(1'b0, 1'b1, 8'hFF);
    add(1'b0, 1'b1, 8'h00);
    add(1'b0, 1'b1, 8'h01);
    // 27..29: reset priority from 0x37
    add(1'b1, 1'b1, 8'h00);
    add(1'b1, 1'b1, 8'h00);
    add(1'b0, 1'b1, 8'h01);

    // Defined power-up value before any edge.
    #1;
    check("powerup_init", 8'h00);

    run_table("basic", 0, 24);

    // Toggle d between edges: q must not move until an edge, and the
    // edge only sees the final (low) value of d.
    #3;  d = 1'b1;
    #5;  check("midcycle_a", 8'h07);
    d = 1'b0;
    #5;  check("midcycle_b", 8'h07);
    d = 1'b1;
    #5;  check("midcycle_c", 8'h07);
    d = 1'b0;
    @(posedge clk);
    #1;
    check("midcycle_edge", 8'h07);

    // Preload to FE from 7.
    for (int i = 0; i < 247; i++) step(1'b0, 1'b1);
    check("preload_fe", 8'hFE);
    run_table("wrap", 24, 27);

    // Preload to 0x37 from a cleared counter.
    step(1'b1, 1'b0);
    for (int i = 0; i < 8'h37; i++) step(1'b0, 1'b1);
    check("preload_37", 8'h37);
    run_table("rstprio", 27, 30);

    // Asynchronous phase: start from a known zero, offset the input
    // toggles by half a nanosecond so they never coincide with an edge.
    step(1'b1, 1'b0);
    check("async_start", 8'h00);
    model_q = 8'h00;
    @(posedge clk);
    #0.5;
    model_q = 8'h00;
    reset = 1'b0;
    d     = 1'b1;
    fork
      begin
        for (int k = 0; k < 58; k++) #17 d = ~d;
      end
      begin
        for (int k = 0; k < 9; k++) #102 reset = ~reset;
      end
      begin
        for (int k = 0; k < 25; k++) begin
          @(posedge clk);
          smp_r = reset;
          smp_d = d;
          if (smp_r)      model_q = 8'h00;
          else if (smp_d) model_q = model_q + 8'h01;
          #1;
          check($sformatf("async_edge[%0d]", k), model_q);
          #37;
          check($sformatf("async_hold[%0d]", k), model_q);
        end
      end
    join

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
